// File: rtl/m_macandn_filt.sv
// Wide all-ones decode: six-input AND leaf tree (optionally pipelined) feeding a
// consecutive-cycle qualification filter. Define MACANDN_STICKY_EN for CLR/QS.
module m_macandn_filt #(
  parameter int WIDTH  = 36,
  parameter int PIPE   = 1,
  parameter int FILTER = 1
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic [WIDTH-1:0] A,
  input  logic             EN,
`ifdef MACANDN_STICKY_EN
  input  logic             CLR,
  output logic             QS,
`endif
  output logic             Q,
  output logic             QR
);

  localparam int L  = (PIPE == 0 || WIDTH <= 6) ? 1 : (WIDTH <= 36) ? 2 : 3;
  localparam int N1 = (WIDTH + 5) / 6;
  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILTER);

  // Leaf cell: NAND followed by an inverter.
  function automatic logic leaf6(input logic [5:0] x);
    logic nand_n;
    nand_n = ~&x;
    return ~nand_n;
  endfunction

  logic [6*N1-1:0] a_pad;
  logic [N1-1:0]   lvl1_c;
  logic            r_d;
  logic            r_q;

  always_comb begin
    a_pad = '1;
    a_pad[WIDTH-1:0] = A;
    for (int i = 0; i < N1; i++) lvl1_c[i] = leaf6(a_pad[6*i +: 6]);
  end

  generate
    if (PIPE == 0) begin : g_comb
      localparam int N2 = (N1 + 5) / 6;
      logic [6*N2-1:0] l1_pad;
      logic [N2-1:0]   lvl2_c;
      logic [5:0]      l2_pad;
      always_comb begin
        l1_pad = '1;
        l1_pad[N1-1:0] = lvl1_c;
        for (int i = 0; i < N2; i++) lvl2_c[i] = leaf6(l1_pad[6*i +: 6]);
        l2_pad = '1;
        l2_pad[N2-1:0] = lvl2_c;
        r_d = leaf6(l2_pad);
      end
    end else if (L == 1) begin : g_l1
      assign r_d = lvl1_c[0];
    end else if (L == 2) begin : g_l2
      logic [N1-1:0] lvl1_q;
      logic [5:0]    l1_pad;
      always_ff @(posedge MasterClock) begin
        if (!RESETL) lvl1_q <= '0;
        else         lvl1_q <= lvl1_c;
      end
      always_comb begin
        l1_pad = '1;
        l1_pad[N1-1:0] = lvl1_q;
        r_d = leaf6(l1_pad);
      end
    end else begin : g_l3
      localparam int N2 = (N1 + 5) / 6;
      logic [N1-1:0]   lvl1_q;
      logic [6*N2-1:0] l1_pad;
      logic [N2-1:0]   lvl2_c;
      logic [N2-1:0]   lvl2_q;
      logic [5:0]      l2_pad;
      always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
          lvl1_q <= '0;
          lvl2_q <= '0;
        end else begin
          lvl1_q <= lvl1_c;
          lvl2_q <= lvl2_c;
        end
      end
      always_comb begin
        l1_pad = '1;
        l1_pad[N1-1:0] = lvl1_q;
        for (int i = 0; i < N2; i++) lvl2_c[i] = leaf6(l1_pad[6*i +: 6]);
        l2_pad = '1;
        l2_pad[N2-1:0] = lvl2_q;
        r_d = leaf6(l2_pad);
      end
    end
  endgenerate

  always_ff @(posedge MasterClock) begin
    if (!RESETL) r_q <= 1'b0;
    else         r_q <= r_d;
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          qr_q, qr_d;

  // Any false sample or EN low restarts qualification; the count saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!EN || !r_q)        cnt_d = '0;
    else if (cnt_q < FMAX)  cnt_d = cnt_q + CW'(1);
    qr_d = (cnt_d == FMAX) && (cnt_q != FMAX);
  end

  always_ff @(posedge MasterClock) begin
    if (!RESETL) begin
      cnt_q <= '0;
      qr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      qr_q  <= qr_d;
    end
  end

  assign Q  = (cnt_q == FMAX);
  assign QR = qr_q;

`ifdef MACANDN_STICKY_EN
  logic qs_q, qs_d;

  // Set has priority over clear when both land on the same edge.
  always_comb begin
    qs_d = qs_q;
    if (qr_q)     qs_d = 1'b1;
    else if (CLR) qs_d = 1'b0;
  end

  always_ff @(posedge MasterClock) begin
    if (!RESETL) qs_q <= 1'b0;
    else         qs_q <= qs_d;
  end

  assign QS = qs_q;
`endif

endmodule

// File: tb/tb_m_macandn_filt.sv
// Bench for m_macandn_filt: five configurations driven together, checked each
// cycle against a windowed reference model; QS checks with MACANDN_STICKY_EN.
module tb_m_macandn_filt;

  localparam int NI   = 5;
  localparam int MAXE = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstl, en, clr;
  logic [5:0]   a0;
  logic [35:0]  a1;
  logic [99:0]  a2;
  logic [199:0] a3;
  logic [19:0]  a4;
  logic [NI-1:0] q_v, qr_v;
`ifdef MACANDN_STICKY_EN
  logic [NI-1:0] qs_v;
`endif

  m_macandn_filt #(.WIDTH(6), .PIPE(1), .FILTER(1)) u0 (
    .MasterClock(clk), .RESETL(rstl), .A(a0), .EN(en),
`ifdef MACANDN_STICKY_EN
    .CLR(clr), .QS(qs_v[0]),
`endif
    .Q(q_v[0]), .QR(qr_v[0]));

  m_macandn_filt #(.WIDTH(36), .PIPE(1), .FILTER(4)) u1 (
    .MasterClock(clk), .RESETL(rstl), .A(a1), .EN(en),
`ifdef MACANDN_STICKY_EN
    .CLR(clr), .QS(qs_v[1]),
`endif
    .Q(q_v[1]), .QR(qr_v[1]));

  m_macandn_filt #(.WIDTH(100), .PIPE(0), .FILTER(1)) u2 (
    .MasterClock(clk), .RESETL(rstl), .A(a2), .EN(en),
`ifdef MACANDN_STICKY_EN
    .CLR(clr), .QS(qs_v[2]),
`endif
    .Q(q_v[2]), .QR(qr_v[2]));

  m_macandn_filt #(.WIDTH(200), .PIPE(1), .FILTER(3)) u3 (
    .MasterClock(clk), .RESETL(rstl), .A(a3), .EN(en),
`ifdef MACANDN_STICKY_EN
    .CLR(clr), .QS(qs_v[3]),
`endif
    .Q(q_v[3]), .QR(qr_v[3]));

  m_macandn_filt #(.WIDTH(20), .PIPE(1), .FILTER(10)) u4 (
    .MasterClock(clk), .RESETL(rstl), .A(a4), .EN(en),
`ifdef MACANDN_STICKY_EN
    .CLR(clr), .QS(qs_v[4]),
`endif
    .Q(q_v[4]), .QR(qr_v[4]));

  // Tree depth and filter length of each instance, from the width rules.
  function automatic int lk(int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 1;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int fk(int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 3;
      default: return 10;
    endcase
  endfunction

  bit h_rst [MAXE];
  bit h_en  [MAXE];
  bit h_clr [MAXE];
  bit h_all [NI][MAXE];
  bit qs_m  [NI];
  int e = 0;
  int checks = 0;
  int errors = 0;

  // Q after edge n: no reset anywhere in the last L+F edges, EN high on the last
  // F edges, and A all-ones at each of those edges delayed by L.
  function automatic bit mq(int k, int n);
    int f, l;
    f = fk(k);
    l = lk(k);
    if (n - f + 1 - l < 0) return 1'b0;
    for (int i = n - f + 1 - l; i <= n; i++) if (h_rst[i]) return 1'b0;
    for (int j = n - f + 1; j <= n; j++)
      if (!h_en[j] || !h_all[k][j-l]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit mqr(int k, int n);
    return mq(k, n) && !mq(k, n - 1);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (e >= MAXE) begin
      $display("FAIL history_overflow: observed=%0d expected<%0d", e, MAXE);
      $fatal(1, "edge budget exceeded");
    end
    h_rst[e] = !rstl;
    h_en[e]  = en;
    h_clr[e] = clr;
    h_all[0][e] = &a0;
    h_all[1][e] = &a1;
    h_all[2][e] = &a2;
    h_all[3][e] = &a3;
    h_all[4][e] = &a4;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("q%0d@%0d", k, e), q_v[k], mq(k, e));
      chk($sformatf("qr%0d@%0d", k, e), qr_v[k], mqr(k, e));
`ifdef MACANDN_STICKY_EN
      if (h_rst[e])             qs_m[k] = 1'b0;
      else if (mqr(k, e - 1))   qs_m[k] = 1'b1;
      else if (h_clr[e])        qs_m[k] = 1'b0;
      chk($sformatf("qs%0d@%0d", k, e), qs_v[k], qs_m[k]);
`endif
    end
    e++;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) qs_m[k] = 1'b0;
    rstl = 1'b0; en = 1'b1; clr = 1'b0;
    a0 = '1; a1 = '1; a2 = '1; a3 = '1; a4 = '1;

    // Reset then release with all-ones
    repeat (3) step();
    chk("rst_q0", q_v[0], 1'b0);
    chk("rst_qr0", qr_v[0], 1'b0);
    rstl = 1'b1;
    step();
    chk("rise_q0_early", q_v[0], 1'b0);
    step();
    chk("rise_q0", q_v[0], 1'b1);
    chk("rise_qr0", qr_v[0], 1'b1);
    chk("pipe0_rise_q2", q_v[2], 1'b1);
    step();
    chk("qr0_single", qr_v[0], 1'b0);
    chk("q0_hold", q_v[0], 1'b1);

    // Glitch filtering on the 36-wide, FILTER=4 instance
    a1[17] = 1'b0;
    repeat (3) step();
    a1 = '1;
    repeat (2) step();
    a1[17] = 1'b0;
    step();
    a1 = '1;
    repeat (5) begin
      step();
      chk("glitch_q1_low", q_v[1], 1'b0);
    end
    step();
    chk("glitch_q1_rise", q_v[1], 1'b1);
    a1[17] = 1'b0;
    step();
    chk("fall_q1_hold1", q_v[1], 1'b1);
    step();
    chk("fall_q1_hold2", q_v[1], 1'b1);
    step();
    chk("fall_q1", q_v[1], 1'b0);
    a1 = '1;

    // Top bit of the combinational 100-wide tree
    a2[99] = 1'b0;
    step();
    chk("p0_hold_q2", q_v[2], 1'b1);
    step();
    chk("p0_fall_q2", q_v[2], 1'b0);
    a2 = '1;

    // EN gating on the FILTER=3, three-level instance
    chk("en_q3_pre", q_v[3], 1'b1);
    en = 1'b0;
    step();
    chk("en_q3_fall", q_v[3], 1'b0);
    en = 1'b1;
    step();
    chk("en_q3_wait1", q_v[3], 1'b0);
    step();
    chk("en_q3_wait2", q_v[3], 1'b0);
    step();
    chk("en_q3_rise", q_v[3], 1'b1);
    chk("en_qr3_again", qr_v[3], 1'b1);
    step();
`ifdef MACANDN_STICKY_EN
    chk("qs3_set", qs_v[3], 1'b1);
`endif
    en = 1'b0;
    step();
`ifdef MACANDN_STICKY_EN
    chk("qs3_hold_after_fall", qs_v[3], 1'b1);
`endif
    en = 1'b1;
    repeat (3) step();
    chk("qr3_third", qr_v[3], 1'b1);
    clr = 1'b1;
    step();
`ifdef MACANDN_STICKY_EN
    chk("qs3_set_wins", qs_v[3], 1'b1);
`endif
    step();
`ifdef MACANDN_STICKY_EN
    chk("qs3_clear", qs_v[3], 1'b0);
`endif
    clr = 1'b0;

    // Reset partway through a FILTER=10 count
    a4[0] = 1'b0;
    step();
    a4 = '1;
    repeat (9) step();
    rstl = 1'b0;
    step();
    rstl = 1'b1;
    repeat (11) begin
      step();
      chk("rstmid_q4_low", q_v[4], 1'b0);
    end
    step();
    chk("rstmid_q4_rise", q_v[4], 1'b1);

    // Randomised traffic, mostly all-ones with sparse dropped bits
    repeat (400) begin
      rstl = ($urandom_range(59) != 0);
      en   = ($urandom_range(15) != 0);
      clr  = ($urandom_range(7) == 0);
      a0 = '1; a1 = '1; a2 = '1; a3 = '1; a4 = '1;
      if ($urandom_range(7) == 0) a0[$urandom_range(5)] = 1'b0;
      if ($urandom_range(9) == 0) a1[$urandom_range(35)] = 1'b0;
      if ($urandom_range(7) == 0) a2[$urandom_range(99)] = 1'b0;
      if ($urandom_range(9) == 0) a3[$urandom_range(199)] = 1'b0;
      if ($urandom_range(19) == 0) a4[$urandom_range(19)] = 1'b0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
